// File: rtl/reg_writeback_pkg.sv
// reg_writeback_pkg: shared writeback entry type and register-file sizing
package reg_writeback_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    function automatic int reg_count(input int aw);
        return 1 << aw;
    endfunction

    localparam int NUM_REGS = reg_count(REG_ADDR_W);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular writeback queue with head/tail/count, cleared on reset
module wb_fifo
    import reg_writeback_pkg::*;
#(
    parameter int W     = $bits(wb_entry_t),
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head, tail;

    assign dout = mem[head];

    // Storage and pointers; a push and pop together leave count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '{default: '0};
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= din;
                tail      <= (tail == PW'(DEPTH-1)) ? '0 : tail + 1'b1;
            end
            if (pop)
                head <= (head == PW'(DEPTH-1)) ? '0 : head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: arbitrates load/ALU results into a write queue and tracks pending destinations
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_W,
    parameter int REG_ADDR_WIDTH = REG_ADDR_W,
    parameter int DEPTH          = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ld_valid,
    input  logic [REG_ADDR_WIDTH-1:0] ld_rd,
    input  logic [DATA_WIDTH-1:0]     ld_data,
    output logic                      ld_ready,
    input  logic                      alu_valid,
    input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]     alu_data,
    output logic                      alu_ready,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    output logic                      issue_ready,
    input  logic [REG_ADDR_WIDTH-1:0] rs1,
    input  logic [REG_ADDR_WIDTH-1:0] rs2,
    output logic                      busy1,
    output logic                      busy2,
    output logic                      WE3,
    output logic [REG_ADDR_WIDTH-1:0] AD3,
    output logic [DATA_WIDTH-1:0]     WD3
);

    localparam int NREGS = reg_count(REG_ADDR_WIDTH);
    localparam int CW    = $clog2(DEPTH+1);
    localparam int EW    = REG_ADDR_WIDTH + DATA_WIDTH;

    logic [CW-1:0]    count;
    logic [EW-1:0]    head_entry, enq_entry;
    logic             deq, ld_fire, alu_fire, enq;
    logic [NREGS-1:0] pending, pending_nxt;

    assign deq         = count != '0;
    assign WE3         = deq;
    assign {AD3, WD3}  = head_entry;
    assign ld_ready    = (count < CW'(DEPTH)) || deq;
    assign alu_ready   = ld_ready && !ld_valid;
    assign ld_fire     = ld_valid && ld_ready;
    assign alu_fire    = alu_valid && alu_ready;
    // Writes to r0 complete the handshake but are never queued
    assign enq         = (ld_fire && ld_rd != '0) || (alu_fire && alu_rd != '0);
    assign enq_entry   = ld_valid ? {ld_rd, ld_data} : {alu_rd, alu_data};
    assign issue_ready = !pending[issue_rd];
    assign busy1       = pending[rs1];
    assign busy2       = pending[rs2];

    wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (enq),
        .din   (enq_entry),
        .pop   (deq),
        .dout  (head_entry),
        .count (count)
    );

    // Scoreboard update: retire the written register, mark a newly issued one; r0 never pending
    always_comb begin
        pending_nxt = pending;
        if (deq)
            pending_nxt[AD3] = 1'b0;
        if (issue_valid && issue_ready)
            pending_nxt[issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: randomized scoreboard bench with a queue-level reference model
module tb_reg_writeback;
    import reg_writeback_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid, alu_valid, issue_valid;
    logic [4:0]  ld_rd, alu_rd, issue_rd, rs1, rs2;
    logic [31:0] ld_data, alu_data;
    logic        ld_ready, alu_ready, issue_ready, busy1, busy2, WE3;
    logic [4:0]  AD3;
    logic [31:0] WD3;

    int checks = 0;
    int errors = 0;

    wb_entry_t   exp_q[$];
    logic [4:0]  pipe[$];
    logic [31:0] pend;

    always #5 clk = ~clk;

    reg_writeback #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1(rs1), .rs2(rs2), .busy1(busy1), .busy2(busy2),
        .WE3(WE3), .AD3(AD3), .WD3(WD3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every register-file write must match the oldest expected result
    always @(negedge clk) begin : mon
        wb_entry_t e;
        if (rst_n === 1'b1 && WE3 === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL write: unexpected rd=%0d data=0x%0h expected no write", AD3, WD3);
            end else begin
                e = exp_q.pop_front();
                chk("AD3", 32'(AD3), 32'(e.rd));
                chk("WD3", WD3, e.data);
            end
        end
    end

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1
    task automatic step(input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                        input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic iv, input logic [4:0] ird,
                        input logic [4:0] r1, input logic [4:0] r2);
        logic       rdy, ir;
        logic [4:0] r;
        wb_entry_t  e;
        ld_valid = lv; ld_rd = lrd; ld_data = ldd;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        issue_valid = iv; issue_rd = ird; rs1 = r1; rs2 = r2;
        @(negedge clk);
        rdy = (pipe.size() < DEPTH) || (pipe.size() != 0);
        ir  = !pend[ird];
        chk("ld_ready", 32'(ld_ready), 32'(rdy));
        chk("alu_ready", 32'(alu_ready), 32'(rdy && !lv));
        chk("issue_ready", 32'(issue_ready), 32'(ir));
        chk("busy1", 32'(busy1), 32'(pend[r1]));
        chk("busy2", 32'(busy2), 32'(pend[r2]));
        chk("WE3", 32'(WE3), 32'(pipe.size() != 0));
        if (pipe.size() != 0) begin
            r = pipe.pop_front();
            pend[r] = 1'b0;
        end
        if (iv && ir && ird != 0) pend[ird] = 1'b1;
        if (lv && rdy) begin
            if (lrd != 0) begin
                e.rd = lrd; e.data = ldd;
                pipe.push_back(lrd); exp_q.push_back(e);
            end
        end else if (av && rdy) begin
            if (ard != 0) begin
                e.rd = ard; e.data = ad;
                pipe.push_back(ard); exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] ird);
        step(0, 0, 0, 0, 0, 0, 0, ird, r1, 0);
    endtask

    task automatic rand_step();
        step(1'($urandom), 5'($urandom), $urandom,
             1'($urandom), 5'($urandom), $urandom,
             1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
    endtask

    initial begin
        pend = '0;
        rst_n = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h55;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        issue_valid = 1'b0; issue_rd = 5'd4; rs1 = 5'd3; rs2 = 5'd7;
        repeat (2) @(posedge clk);
        #1;
        chk("rst WE3", 32'(WE3), 0);
        chk("rst AD3", 32'(AD3), 0);
        chk("rst WD3", WD3, 0);
        chk("rst busy1", 32'(busy1), 0);
        chk("rst busy2", 32'(busy2), 0);
        chk("rst issue_ready", 32'(issue_ready), 1);
        chk("rst ld_ready", 32'(ld_ready), 1);
        chk("rst alu_ready ld_valid=1", 32'(alu_ready), 0);
        ld_valid = 1'b0;
        #1;
        chk("rst alu_ready ld_valid=0", 32'(alu_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single load, written next cycle, then idle
        step(1, 5'd10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0);
        idle(0, 0);

        // load beats ALU, ALU held and accepted next cycle
        step(1, 5'd5, 32'hA5A5_0005, 1, 5'd6, 32'h6666_0006, 0, 0, 0, 0);
        step(0, 0, 0, 1, 5'd6, 32'h6666_0006, 0, 0, 0, 0);
        idle(0, 0);
        idle(0, 0);

        // scoreboard set on issue, cleared when the write leaves the queue
        step(0, 0, 0, 0, 0, 0, 1, 5'd11, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 5'd11, 5'd11, 5'd11);
        step(1, 5'd11, 32'h0000_0B0B, 0, 0, 0, 0, 5'd11, 5'd11, 0);
        idle(5'd11, 5'd11);
        idle(5'd11, 5'd11);

        // r0 results discarded; issue to r0 leaves busy low
        step(0, 0, 0, 1, 5'd0, 32'h1234, 1, 5'd0, 0, 0);
        idle(0, 0);
        idle(0, 0);

        repeat (600) rand_step();

        // reset mid-cycle with a result queued and a register pending
        step(1, 5'd7, 32'h7777_0007, 0, 0, 0, 1, 5'd9, 5'd9, 0);
        ld_valid = 1'b0; alu_valid = 1'b0; issue_valid = 1'b0;
        rs1 = 5'd9; rs2 = 5'd7; issue_rd = 5'd9;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst WE3", 32'(WE3), 0);
        chk("midrst busy1", 32'(busy1), 0);
        chk("midrst issue_ready", 32'(issue_ready), 1);
        chk("midrst ld_ready", 32'(ld_ready), 1);
        pipe.delete();
        exp_q.delete();
        pend = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5'd9, 5'd7);
        idle(5'd9, 5'd7);

        repeat (300) rand_step();
        repeat (DEPTH + 2) idle(0, 0);
        chk("drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
